// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase scheduler:
// state encoding, approach group codes, lane indices and lane/group mapping.
package traffic_pkg;

    localparam int unsigned NUM_LANES  = 8;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned NUM_GROUPS = 4;
    localparam int unsigned DEMAND_W   = 5;
    localparam int unsigned CNT_W      = 8;

    // Lane index inside the packed occupancy bus (byte k lives at [8k+7:8k]).
    localparam int unsigned LANE_W1 = 7;
    localparam int unsigned LANE_W2 = 6;
    localparam int unsigned LANE_S1 = 5;
    localparam int unsigned LANE_S2 = 4;
    localparam int unsigned LANE_E1 = 3;
    localparam int unsigned LANE_E2 = 2;
    localparam int unsigned LANE_N1 = 1;
    localparam int unsigned LANE_N2 = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GREEN    = 3'd1,
        ST_YELLOW   = 3'd2,
        ST_ALLRED   = 3'd3,
        ST_PED_WALK = 3'd4,
        ST_EMG      = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        GRP_W = 2'd0,
        GRP_S = 2'd1,
        GRP_E = 2'd2,
        GRP_N = 2'd3
    } group_e;

    // Lanes 7,6 -> W; 5,4 -> S; 3,2 -> E; 1,0 -> N.
    function automatic logic [1:0] lane_to_group(input logic [2:0] lane);
        return ~lane[2:1];
    endfunction

    function automatic logic [7:0] group_mask(input logic [1:0] grp);
        return 8'hC0 >> {grp, 1'b0};
    endfunction

endpackage

// File: rtl/group_demand.sv
// Group demand: total number of occupied bits across the two lane bytes of one approach.
module group_demand
    import traffic_pkg::*;
(
    input  logic [LANE_W-1:0]   lane_a_i,
    input  logic [LANE_W-1:0]   lane_b_i,
    output logic [DEMAND_W-1:0] demand_c_o
);

    always_comb begin
        demand_c_o = '0;
        for (int unsigned i = 0; i < LANE_W; i++) begin
            demand_c_o = demand_c_o + DEMAND_W'(lane_a_i[i]) + DEMAND_W'(lane_b_i[i]);
        end
    end

endmodule

// File: rtl/phase_arbiter.sv
// Round-robin green-phase scheduler for the four-approach intersection.
// Define PHASE_ARB_PED_EN to compile in the pedestrian latch and walk phase.
module phase_arbiter
    import traffic_pkg::*;
#(
    parameter int unsigned YELLOW_TIME   = 3,
    parameter int unsigned ALLRED_TIME   = 1,
    parameter int unsigned MIN_GREEN     = 4,
    parameter int unsigned GREEN_PER_CAR = 1,
    parameter int unsigned MAX_GREEN     = 20,
    parameter int unsigned NIGHT_GREEN   = 6,
    parameter int unsigned PED_TIME      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_LANES*LANE_W-1:0] lanes,
    input  logic                      nightMode,
    input  logic                      pedSignal,
    input  logic                      emgSignal,
    input  logic [NUM_LANES-1:0]      emgLane,
    output logic [NUM_LANES-1:0]      greenMask,
    output logic [NUM_LANES-1:0]      yellowMask,
    output logic [NUM_LANES-1:0]      walkMask,
    output logic [2:0]                phase,
    output logic [1:0]                activeGroup,
    output logic [CNT_W-1:0]          countdown,
    output logic                      emgActive
);

    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] PED_LOAD    = CNT_W'(PED_TIME - 1);

    logic [DEMAND_W-1:0] demand [NUM_GROUPS];

    phase_e            state_q, state_d, arb_state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, arb_cnt_d;
    logic [1:0]        group_q, group_d, arb_group_d;
    logic [1:0]        last_q, last_d;
    logic              ped_q, ped_blk_q;

    logic              emg_valid;
    logic [1:0]        emg_group;
    logic              rr_found;
    logic [1:0]        rr_group, cand;
    logic [8:0]        len9;
    logic [CNT_W-1:0]  green_len, green_load;
    logic              ped_ok, arb_now;

    group_demand u_dem_w (.lane_a_i(lanes[LANE_W1*LANE_W +: LANE_W]),
                          .lane_b_i(lanes[LANE_W2*LANE_W +: LANE_W]), .demand_c_o(demand[0]));
    group_demand u_dem_s (.lane_a_i(lanes[LANE_S1*LANE_W +: LANE_W]),
                          .lane_b_i(lanes[LANE_S2*LANE_W +: LANE_W]), .demand_c_o(demand[1]));
    group_demand u_dem_e (.lane_a_i(lanes[LANE_E1*LANE_W +: LANE_W]),
                          .lane_b_i(lanes[LANE_E2*LANE_W +: LANE_W]), .demand_c_o(demand[2]));
    group_demand u_dem_n (.lane_a_i(lanes[LANE_N1*LANE_W +: LANE_W]),
                          .lane_b_i(lanes[LANE_N2*LANE_W +: LANE_W]), .demand_c_o(demand[3]));

    // Emergency target: highest set bit of emgLane wins.
    always_comb begin
        emg_valid = emgSignal && (emgLane != '0);
        emg_group = GRP_W;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (emgLane[i]) emg_group = lane_to_group(3'(i));
        end
    end

    // Arbitration decision: emergency, pedestrian, round-robin green, or idle.
    always_comb begin
        rr_found = 1'b0;
        rr_group = last_q;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_GROUPS; i++) begin
            cand = last_q + 2'(i);
            if (!rr_found && (demand[cand] != '0)) begin
                rr_found = 1'b1;
                rr_group = cand;
            end
        end

        len9 = 9'(MIN_GREEN) + 9'(GREEN_PER_CAR) * 9'(demand[rr_group]);
        if (len9 > 9'(MAX_GREEN)) len9 = 9'(MAX_GREEN);
        green_len  = nightMode ? CNT_W'(NIGHT_GREEN)
                               : ((len9 > 9'd255) ? 8'hFF : len9[7:0]);
        green_load = (green_len == '0) ? '0 : green_len - 8'd1;

        // A pending walk yields to one vehicle phase after the previous walk.
        ped_ok = ped_q && (!ped_blk_q || !rr_found);

        arb_state_d = ST_IDLE;
        arb_cnt_d   = '0;
        arb_group_d = group_q;
        if (emg_valid) begin
            arb_state_d = ST_EMG;
            arb_group_d = emg_group;
        end else if (ped_ok) begin
            arb_state_d = ST_PED_WALK;
            arb_cnt_d   = PED_LOAD;
        end else if (rr_found) begin
            arb_state_d = ST_GREEN;
            arb_cnt_d   = green_load;
            arb_group_d = rr_group;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        group_d = group_q;
        last_d  = last_q;
        arb_now = 1'b0;
        unique case (state_q)
            ST_IDLE: arb_now = 1'b1;
            ST_GREEN: begin
                if (emg_valid && (emg_group == group_q)) begin
                    state_d = ST_EMG;
                    cnt_d   = '0;
                    last_d  = emg_group;
                end else if (emg_valid || (cnt_q == '0)) begin
                    state_d = ST_YELLOW;
                    cnt_d   = YELLOW_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_ALLRED;
                    cnt_d   = ALLRED_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ALLRED: begin
                if (cnt_q == '0) arb_now = 1'b1;
                else             cnt_d   = cnt_q - 8'd1;
            end
            ST_PED_WALK: begin
                if (emg_valid || (cnt_q == '0)) begin
                    state_d = ST_ALLRED;
                    cnt_d   = ALLRED_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_EMG: begin
                if (!emgSignal) begin
                    state_d = ST_YELLOW;
                    cnt_d   = YELLOW_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (arb_now) begin
            state_d = arb_state_d;
            cnt_d   = arb_cnt_d;
            if ((arb_state_d == ST_GREEN) || (arb_state_d == ST_EMG)) begin
                group_d = arb_group_d;
                last_d  = arb_group_d;
            end
        end
    end

    // State and Moore outputs decoded from the next state, registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            group_q    <= GRP_W;
            last_q     <= GRP_N;
            greenMask  <= '0;
            yellowMask <= '0;
            emgActive  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            group_q    <= group_d;
            last_q     <= last_d;
            greenMask  <= ((state_d == ST_GREEN) || (state_d == ST_EMG)) ? group_mask(group_d) : '0;
            yellowMask <= (state_d == ST_YELLOW) ? group_mask(group_d) : '0;
            emgActive  <= (state_d == ST_EMG);
        end
    end

    assign phase       = state_q;
    assign activeGroup = group_q;
    assign countdown   = cnt_q;

`ifdef PHASE_ARB_PED_EN
    logic ped_d, ped_blk_d;

    // Request latch; the block flag defers a repeat walk past one vehicle phase.
    always_comb begin
        ped_d     = ped_q | pedSignal;
        ped_blk_d = ped_blk_q;
        if ((state_d == ST_PED_WALK) && (state_q != ST_PED_WALK)) begin
            ped_d     = 1'b0;
            ped_blk_d = 1'b1;
        end else if ((state_d == ST_GREEN) || (state_d == ST_EMG)) begin
            ped_blk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_q     <= 1'b0;
            ped_blk_q <= 1'b0;
            walkMask  <= '0;
        end else begin
            ped_q     <= ped_d;
            ped_blk_q <= ped_blk_d;
            walkMask  <= (state_d == ST_PED_WALK) ? 8'hFF : '0;
        end
    end
`else
    logic unused_ped;
    assign unused_ped = pedSignal;
    assign ped_q      = 1'b0;
    assign ped_blk_q  = 1'b0;
    assign walkMask   = '0;
`endif

endmodule

// File: tb/tb_phase_arbiter.sv
// Self-checking bench for phase_arbiter: directed phase-length scenarios plus
// randomized traffic compared each cycle against a phase/remaining-time model.
module tb_phase_arbiter;
    import traffic_pkg::*;

    localparam int YT = 3, AT = 1, MING = 4, GPC = 1, MAXG = 20, NG = 6, PT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] lanes = '0;
    logic        nightMode = 1'b0, pedSignal = 1'b0, emgSignal = 1'b0;
    logic [7:0]  emgLane = '0;
    logic [7:0]  greenMask, yellowMask, walkMask, countdown;
    logic [2:0]  phase;
    logic [1:0]  activeGroup;
    logic        emgActive;

    always #5 clk = ~clk;

    phase_arbiter #(
        .YELLOW_TIME(YT), .ALLRED_TIME(AT), .MIN_GREEN(MING), .GREEN_PER_CAR(GPC),
        .MAX_GREEN(MAXG), .NIGHT_GREEN(NG), .PED_TIME(PT)
    ) dut (
        .clk(clk), .rst(rst), .lanes(lanes), .nightMode(nightMode), .pedSignal(pedSignal),
        .emgSignal(emgSignal), .emgLane(emgLane), .greenMask(greenMask),
        .yellowMask(yellowMask), .walkMask(walkMask), .phase(phase),
        .activeGroup(activeGroup), .countdown(countdown), .emgActive(emgActive)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: current phase, cycles left in it, served group, round-robin pointer.
    phase_e m_ph;
    int     m_left, m_grp, m_last;
    bit     m_ped, m_pblk;

    function automatic int dem(input int g);
        logic [7:0] a, b;
        a = lanes[(7 - 2*g)*8 +: 8];
        b = lanes[(6 - 2*g)*8 +: 8];
        return $countones(a) + $countones(b);
    endfunction

    function automatic int glen(input int g);
        int l;
        if (nightMode) return NG;
        l = MING + GPC * dem(g);
        if (l > MAXG) l = MAXG;
        if (l > 255) l = 255;
        return l;
    endfunction

    function automatic int emg_tgt();
        for (int i = 7; i >= 0; i--) if (emgLane[i]) return 3 - i/2;
        return 0;
    endfunction

    function automatic logic [7:0] mask_of(input int g);
        logic [7:0] m;
        m = '0;
        m[7 - 2*g] = 1'b1;
        m[6 - 2*g] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_ph = ST_IDLE; m_left = 0; m_grp = 0; m_last = 3; m_ped = 0; m_pblk = 0;
    endtask

    task automatic model_arb();
        bit found;
        int g;
        found = 0; g = 0;
        if (emgSignal && emgLane != 0) begin
            m_ph = ST_EMG; m_left = 0; m_grp = emg_tgt(); m_last = m_grp;
            return;
        end
        for (int k = 1; k <= 4; k++)
            if (!found && dem((m_last + k) % 4) > 0) begin found = 1; g = (m_last + k) % 4; end
        if (m_ped && (!m_pblk || !found)) begin
            m_ph = ST_PED_WALK; m_left = PT;
        end else if (found) begin
            m_ph = ST_GREEN; m_left = glen(g); m_grp = g; m_last = g;
        end else begin
            m_ph = ST_IDLE; m_left = 0;
        end
    endtask

    task automatic model_step();
        phase_e prev;
        bit old_ped, emg_ok;
        prev = m_ph; old_ped = m_ped;
        emg_ok = emgSignal && (emgLane != 0);
        case (m_ph)
            ST_IDLE: model_arb();
            ST_GREEN:
                if (emg_ok && emg_tgt() == m_grp) begin m_ph = ST_EMG; m_left = 0; m_last = m_grp; end
                else if (emg_ok || m_left <= 1) begin m_ph = ST_YELLOW; m_left = YT; end
                else m_left--;
            ST_YELLOW:
                if (m_left <= 1) begin m_ph = ST_ALLRED; m_left = AT; end else m_left--;
            ST_ALLRED:
                if (m_left <= 1) model_arb(); else m_left--;
            ST_PED_WALK:
                if (emg_ok || m_left <= 1) begin m_ph = ST_ALLRED; m_left = AT; end else m_left--;
            ST_EMG:
                if (!emgSignal) begin m_ph = ST_YELLOW; m_left = YT; end
            default: model_reset();
        endcase
`ifdef PHASE_ARB_PED_EN
        m_ped = old_ped | pedSignal;
        if (m_ph == ST_PED_WALK && prev != ST_PED_WALK) begin m_ped = 0; m_pblk = 1; end
        else if (m_ph == ST_GREEN || m_ph == ST_EMG) m_pblk = 0;
`else
        if (prev == ST_PED_WALK && old_ped) m_ped = 0;
`endif
    endtask

    task automatic compare_all();
        logic [7:0] eg, ey, ew;
        int ec;
        eg = (m_ph == ST_GREEN || m_ph == ST_EMG) ? mask_of(m_grp) : 8'h00;
        ey = (m_ph == ST_YELLOW) ? mask_of(m_grp) : 8'h00;
        ew = (m_ph == ST_PED_WALK) ? 8'hFF : 8'h00;
        ec = (m_ph == ST_IDLE || m_ph == ST_EMG) ? 0 : m_left - 1;
        check_eq("phase", 32'(phase), 32'(m_ph));
        check_eq("greenMask", 32'(greenMask), 32'(eg));
        check_eq("yellowMask", 32'(yellowMask), 32'(ey));
        check_eq("walkMask", 32'(walkMask), 32'(ew));
        check_eq("activeGroup", 32'(activeGroup), 32'(m_grp));
        check_eq("countdown", 32'(countdown), 32'(ec));
        check_eq("emgActive", 32'(emgActive), 32'(m_ph == ST_EMG));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1 compare_all();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1 model_reset();
        compare_all();
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_len(input logic [7:0] gm, input logic [7:0] ym, output int n);
        n = 0;
        while (greenMask == gm && yellowMask == ym && n < 100) begin n++; cycle(); end
    endtask

    task automatic single_group();
        lanes = '0;
        lanes[7*8 +: 8] = 8'b00110000;
        lanes[6*8 +: 8] = 8'b00001110;
    endtask

    int n, emg_hold;

    initial begin
        #2;
        // Zero demand stays idle.
        do_reset();
        repeat (20) cycle();
        check_eq("zero_dem_green", 32'(greenMask), 32'h0);
        check_eq("zero_dem_phase", 32'(phase), 32'(ST_IDLE));

        // Single group, day timing: 9 green, 3 yellow, 1 all-red, re-grant.
        single_group();
        do_reset();
        check_eq("idle_after_rst", 32'(phase), 32'(ST_IDLE));
        cycle();
        run_len(8'hC0, 8'h00, n); check_eq("w_green_len", 32'(n), 32'd9);
        run_len(8'h00, 8'hC0, n); check_eq("w_yellow_len", 32'(n), 32'd3);
        run_len(8'h00, 8'h00, n); check_eq("w_allred_len", 32'(n), 32'd1);
        check_eq("w_regrant", 32'(greenMask), 32'hC0);

        // Night timing.
        nightMode = 1'b1;
        do_reset();
        cycle();
        run_len(8'hC0, 8'h00, n); check_eq("night_green_len", 32'(n), 32'd6);
        nightMode = 1'b0;

        // Round-robin with cap: W capped at 20, then N for 6, then W again.
        lanes = '0;
        lanes[63:48] = 16'hFFFF;
        lanes[7:0]   = 8'b00000011;
        do_reset();
        cycle();
        run_len(8'hC0, 8'h00, n); check_eq("w_cap_len", 32'(n), 32'd20);
        run_len(8'h00, 8'hC0, n);
        run_len(8'h00, 8'h00, n);
        run_len(8'h03, 8'h00, n); check_eq("n_green_len", 32'(n), 32'd6);
        run_len(8'h00, 8'h03, n);
        run_len(8'h00, 8'h00, n);
        check_eq("rr_back_to_w", 32'(greenMask), 32'hC0);

        // Emergency on E while W is green.
        single_group();
        do_reset();
        repeat (3) cycle();
        emgSignal = 1'b1; emgLane = 8'b00001000;
        cycle();
        check_eq("emg_cut_yellow", 32'(yellowMask), 32'hC0);
        run_len(8'h00, 8'hC0, n);
        run_len(8'h00, 8'h00, n);
        check_eq("emg_green", 32'(greenMask), 32'h0C);
        check_eq("emg_active", 32'(emgActive), 32'd1);
        repeat (4) cycle();
        emgSignal = 1'b0;
        cycle();
        check_eq("emg_exit_yellow", 32'(yellowMask), 32'h0C);
        run_len(8'h00, 8'h0C, n);
        run_len(8'h00, 8'h00, n);
        check_eq("rr_after_emg", 32'(greenMask), 32'hC0);

`ifdef PHASE_ARB_PED_EN
        // Pedestrian pulse during green, then a walk truncated by emergency.
        single_group();
        do_reset();
        repeat (2) cycle();
        pedSignal = 1'b1; cycle(); pedSignal = 1'b0;
        n = 0;
        while (walkMask != 8'hFF && n < 60) begin n++; cycle(); end
        check_eq("ped_walk_green", 32'(greenMask), 32'h0);
        n = 0;
        while (walkMask == 8'hFF && n < 60) begin n++; cycle(); end
        check_eq("ped_walk_len", 32'(n), 32'd8);
        check_eq("ped_to_allred", 32'(phase), 32'(ST_ALLRED));
        cycle();
        check_eq("ped_next_green", 32'(greenMask), 32'hC0);
        pedSignal = 1'b1; cycle(); pedSignal = 1'b0;
        n = 0;
        while (walkMask != 8'hFF && n < 60) begin n++; cycle(); end
        repeat (2) cycle();
        emgSignal = 1'b1; emgLane = 8'b00001000;
        cycle();
        check_eq("ped_trunc_allred", 32'(phase), 32'(ST_ALLRED));
        cycle();
        check_eq("ped_trunc_emg", 32'(emgActive), 32'd1);
        emgSignal = 1'b0;
        repeat (6) cycle();
`endif

        // Randomized traffic against the model, with one mid-run async reset.
        lanes = '0; emgSignal = 1'b0; emgLane = '0; emg_hold = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 24) == 0)
                for (int b = 0; b < 8; b++)
                    lanes[b*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom & $urandom);
            if ($urandom_range(0, 199) == 0) nightMode = ~nightMode;
            pedSignal = ($urandom_range(0, 29) == 0);
            if (emgSignal) begin
                if (emg_hold == 0) emgSignal = 1'b0; else emg_hold--;
            end else if ($urandom_range(0, 119) == 0) begin
                emgSignal = 1'b1;
                emg_hold  = $urandom_range(3, 30);
                emgLane   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            end
            if (c == 1500) begin
                #3 rst = 1'b1;
                #1 model_reset();
                compare_all();
                cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/phase_arbiter.md
# phase_arbiter

Round-robin green-phase scheduler for the four-approach intersection. It takes the eight lane occupancy bytes, the day/night flag, the pedestrian request and the emergency request. It then sequences vehicle green, yellow, all-red, pedestrian-walk and emergency-preempt phases. It sits between the lane sensors and the traffic/walk light drivers on the Breadboard, and replaces the free-running mode countdown as the source of light masks.

## Interface
- `YELLOW_TIME`, 3: yellow phase length in cycles.
- `ALLRED_TIME`, 1: all-red clearance length in cycles.
- `MIN_GREEN`, 4: base green length in day mode.
- `GREEN_PER_CAR`, 1: extra green cycles per occupied lane bit.
- `MAX_GREEN`, 20: cap on day-mode green length.
- `NIGHT_GREEN`, 6: fixed green length in night mode.
- `PED_TIME`, 8: walk phase length.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `lanes`  in  64  occupancy bytes `{w1,w2,s1,s2,e1,e2,n1,n2}`; lane index 7 = w1 … 0 = n2.
- `nightMode`  in  1  1 = night timing.
- `pedSignal`  in  1  pedestrian request; level or pulse.
- `emgSignal`  in  1  emergency active.
- `emgLane`  in  8  one-hot lane of the emergency vehicle, same index order as `lanes`.
- `greenMask`  out  8  per-lane green.
- `yellowMask`  out  8  per-lane yellow.
- `walkMask`  out  8  pedestrian walk lights.
- `phase`  out  3  current FSM state.
- `activeGroup`  out  2  group served: 0 = W, 1 = S, 2 = E, 3 = N.
- `countdown`  out  8  remaining cycles in the current timed phase.
- `emgActive`  out  1  high in the EMG state.

## Operation
- Groups: W = lanes 7,6; S = 5,4; E = 3,2; N = 1,0.
- Lane demand is the popcount of the lane's byte. Group demand is the 5-bit sum of its two lanes' demand (range 0–16).
- States are IDLE, GREEN, YELLOW, ALLRED, PED_WALK and EMG.
- Arbitration runs in IDLE and in the last cycle of ALLRED. Priority order:
  1. Valid emergency → EMG.
  2. Latched pedestrian request → PED_WALK.
  3. First group with nonzero demand, searching round-robin from `lastGroup+1` → GREEN.
  4. Otherwise → IDLE.
- A lone demanding group is re-granted after every ALLRED.
- Green length is latched on entry to GREEN:
  - night: `NIGHT_GREEN`;
  - day: `min(MIN_GREEN + GREEN_PER_CAR*demand, MAX_GREEN)`.
  - Compute in 9 bits, then saturate to 8.
- Phase sequence: GREEN → YELLOW → ALLRED. PED_WALK → ALLRED.
- Emergency is valid when `emgSignal` is high and `emgLane` is nonzero.
  - The target group is taken from the highest set bit of `emgLane`.
  - In GREEN with the target group equal to the active group: go to EMG on the next edge.
  - In GREEN with a different group: go to YELLOW immediately, cutting the green short.
  - In YELLOW: the yellow completes.
  - In PED_WALK: the walk is truncated and the FSM goes to ALLRED.
  - ALLRED always completes before EMG.
- EMG holds green on the target group with `countdown` = 0. When `emgSignal` falls, EMG → YELLOW → ALLRED.
- `lastGroup` is set to the emergency group, so the round-robin resumes after it.
- Pedestrian request handling:
  - The request is latched on any cycle with `pedSignal` high.
  - It is cleared on entry to PED_WALK.
  - A request arriving during PED_WALK re-latches and is served after a full vehicle phase.
- Masks:
  - GREEN and EMG: `greenMask` has the two group lanes set.
  - YELLOW: `yellowMask` has the two group lanes set.
  - PED_WALK: `walkMask` = 8'hFF.
  - All other states: all masks are 0.
- Reset values: IDLE, all masks 0, `countdown` 0, `activeGroup` 0, `lastGroup` = 3 (so W is searched first), pedestrian latch 0, `emgActive` 0.

## Timing
- Outputs are registered and Moore-decoded from the state.
- A timed phase of length N loads `countdown` = N−1 and leaves on the edge after `countdown` == 0, so it lasts exactly N cycles.
- Arbitration and demand sampling use `lanes` as seen in the arbitration cycle.
- A change of `nightMode` mid-green takes effect at the next GREEN entry.
- IDLE re-arbitrates every cycle, so the first green follows 1 IDLE cycle after reset release.
- Emergency cut of GREEN has one cycle of latency: the edge after `emgSignal` is seen high.
- Asserting `rst` mid-phase returns all outputs to reset values asynchronously.

## Configuration
- `PHASE_ARB_PED_EN` defined: pedestrian latch and PED_WALK are compiled in, as described above.
- Undefined: `pedSignal` is ignored, PED_WALK is unreachable, and `walkMask` is tied to 0.

## Structure
- `traffic_pkg` holds:
  - the state enum;
  - the group codes W/S/E/N;
  - lane-index constants;
  - the lane-to-group mapping function.
- Sub-module `group_demand`: combinational popcount of two lane bytes into a 5-bit demand. Instantiated four times.

## Test plan
- Zero demand: all lanes 0, day → stays IDLE; `greenMask` = 0 indefinitely.
- Single group, day: w1 = 8'b00110000, w2 = 8'b00001110, rst pulse → 1 IDLE cycle, then:
  - GREEN W, `greenMask` = 8'b11000000, for 9 cycles;
  - YELLOW 3 cycles, `yellowMask` = 8'b11000000;
  - ALLRED 1 cycle;
  - GREEN W again.
- Round-robin and cap: W demand 16 plus N demand 2 (n2 = 8'b00000011) → W green 20 cycles, then N green 6 cycles, then W again.
- Night: same stimulus as the single-group test with `nightMode` = 1 → W green 6 cycles.
- Emergency: during W green, `emgSignal` = 1, `emgLane` = 8'b00001000 →
  - YELLOW next cycle, ALLRED;
  - EMG with `greenMask` = 8'b00001100, `emgActive` = 1;
  - after drop, YELLOW/ALLRED, then N searched first.
- Pedestrian (with `PHASE_ARB_PED_EN`): 1-cycle `pedSignal` pulse during W green → after ALLRED:
  - PED_WALK 8 cycles with `walkMask` = 8'hFF and `greenMask` = 0;
  - then ALLRED, then the next demanding group.
  - With `emgSignal` raised mid-walk: walk truncated, ALLRED, EMG.
